// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared defines (bus widths, enables, fetch state encoding)
// and the package used by the instruction fetch stage.
//   fetch_state_e : IDLE/RUN state of the fetch unit
//   npc_sel_e     : which rule updates the PC / IF-ID slot on a RUN edge
//   npc_sel()     : applies the flush > stall > branch > sequential priority
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define RstEnable   1'b1
`define RstDisable  1'b0
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define ZeroWord    32'h0000_0000
`define InstAddrBus 31:0
`define InstBus     31:0
`define FetchIdle   1'b0
`define FetchRun    1'b1
`endif

package inst_fetch_pkg;

    typedef enum logic {
        FETCH_IDLE = `FetchIdle,
        FETCH_RUN  = `FetchRun
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_FLUSH,
        NPC_HOLD,
        NPC_BRANCH,
        NPC_SEQ
    } npc_sel_e;

    localparam logic [`InstAddrBus] PC_STEP = 32'd4;

    // Single place where the update priority is decided, so the PC register
    // and the IF/ID register can never disagree about which case applies.
    function automatic npc_sel_e npc_sel(input logic flush, input logic stall,
                                         input logic branch);
        if (flush)       return NPC_FLUSH;
        else if (stall)  return NPC_HOLD;
        else if (branch) return NPC_BRANCH;
        else             return NPC_SEQ;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with next-PC mux, chip-enable generation and the
// IDLE/RUN fetch state.
//   clk, rst     : clock, async active-high reset
//   sel_i        : update rule for this edge (from npc_sel)
//   new_pc_i     : flush redirect address
//   target_i     : branch/jump target
//   pc_o         : current PC (may be unaligned after a flush)
//   ce_o         : instruction memory chip enable
//   addr_o       : word-aligned fetch address, 0 while idle
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [`InstAddrBus] RESET_PC = `ZeroWord
) (
    input  logic                clk,
    input  logic                rst,
    input  npc_sel_e            sel_i,
    input  logic [`InstAddrBus] new_pc_i,
    input  logic [`InstAddrBus] target_i,
    output logic [`InstAddrBus] pc_o,
    output logic                ce_o,
    output logic [`InstAddrBus] addr_o
);

    fetch_state_e        state_q, state_d;
    logic [`InstAddrBus] pc_q, pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_o    = `ChipDisable;
        addr_o  = `ZeroWord;
        case (state_q)
            FETCH_IDLE: begin
                // Redirect inputs are ignored here; the first RUN cycle
                // always fetches RESET_PC.
                state_d = FETCH_RUN;
                pc_d    = RESET_PC;
            end
            FETCH_RUN: begin
                ce_o   = `ChipEnable;
                addr_o = {pc_q[31:2], 2'b00};
                case (sel_i)
                    NPC_FLUSH:  pc_d = new_pc_i;
                    NPC_HOLD:   pc_d = pc_q;
                    NPC_BRANCH: pc_d = target_i;
                    default:    pc_d = pc_q + PC_STEP;
                endcase
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Drives the instruction ROM through
// pc_reg and holds the IF/ID pipeline register plus a fetch counter.
//   clk, rst               : clock, async active-high reset
//   stall, flush, new_pc   : pipeline control (flush > stall priority)
//   branch_flag_i/target   : taken branch resolved in ID (delay slot kept)
//   rom_ce_o/addr_o/inst_i : instruction memory, combinational read
//   id_pc_o/inst_o/valid_o : IF/ID slot presented to decode
//   fetch_cnt_o            : instructions handed to ID, wraps mod 2^32
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [`InstAddrBus] RESET_PC = `ZeroWord
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [`InstAddrBus] new_pc,
    input  logic                branch_flag_i,
    input  logic [`InstAddrBus] branch_target_addr_i,
    output logic                rom_ce_o,
    output logic [`InstAddrBus] rom_addr_o,
    input  logic [`InstBus]     rom_inst_i,
    output logic [`InstAddrBus] id_pc_o,
    output logic [`InstBus]     id_inst_o,
    output logic                id_valid_o,
    output logic [31:0]         fetch_cnt_o
);

    npc_sel_e            sel;
    logic                run;
    logic [`InstAddrBus] pc;

    logic [`InstAddrBus] id_pc_q,   id_pc_d;
    logic [`InstBus]     id_inst_q, id_inst_d;
    logic                id_vld_q,  id_vld_d;
    logic [31:0]         cnt_q,     cnt_d;

    assign sel = npc_sel(flush, stall, branch_flag_i);

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .sel_i   (sel),
        .new_pc_i(new_pc),
        .target_i(branch_target_addr_i),
        .pc_o    (pc),
        .ce_o    (rom_ce_o),
        .addr_o  (rom_addr_o)
    );

    // The IF/ID slot only moves while the fetch unit is running.
    assign run = (rom_ce_o == `ChipEnable);

    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_vld_d  = id_vld_q;
        cnt_d     = cnt_q;
        if (run) begin
            case (sel)
                NPC_FLUSH: begin
                    id_pc_d   = `ZeroWord;
                    id_inst_d = `ZeroWord;
                    id_vld_d  = 1'b0;
                end
                NPC_HOLD: ;
                default: begin
                    // Branch and sequential both hand the current word on;
                    // for a branch this is the delay slot.
                    id_pc_d   = pc;
                    id_inst_d = rom_inst_i;
                    id_vld_d  = 1'b1;
                    cnt_d     = cnt_q + 32'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            id_pc_q   <= `ZeroWord;
            id_inst_q <= `ZeroWord;
            id_vld_q  <= 1'b0;
            cnt_q     <= `ZeroWord;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_vld_q  <= id_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign id_pc_o     = id_pc_q;
    assign id_inst_o   = id_inst_q;
    assign id_valid_o  = id_vld_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, branch_flag_i = 1'b0;
    logic [31:0] new_pc = '0, branch_target_addr_i = '0;
    logic        rom_ce_o, id_valid_o;
    logic [31:0] rom_addr_o, rom_inst_i, id_pc_o, id_inst_o, fetch_cnt_o;

    logic [31:0] rom [0:255];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_inst_i = rom[rom_addr_o[9:2]];

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .flush               (flush),
        .new_pc              (new_pc),
        .branch_flag_i       (branch_flag_i),
        .branch_target_addr_i(branch_target_addr_i),
        .rom_ce_o            (rom_ce_o),
        .rom_addr_o          (rom_addr_o),
        .rom_inst_i          (rom_inst_i),
        .id_pc_o             (id_pc_o),
        .id_inst_o           (id_inst_o),
        .id_valid_o          (id_valid_o),
        .fetch_cnt_o         (fetch_cnt_o)
    );

    // Reference model: running flag, PC and the instruction handed to ID.
    bit          m_run;
    logic [31:0] m_pc, m_idpc, m_inst, m_cnt;
    bit          m_vld;

    function automatic logic [31:0] m_addr();
        return m_run ? (m_pc & 32'hFFFF_FFFC) : 32'h0;
    endfunction

    function automatic logic [129:0] exp_vec();
        return {m_run, m_addr(), m_idpc, m_inst, m_vld, m_cnt};
    endfunction

    function automatic logic [129:0] act_vec();
        return {rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fetch_cnt_o};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pc = RESET_PC; m_idpc = 0; m_inst = 0; m_vld = 0; m_cnt = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        logic [31:0] a;
        a = m_addr();
        if (!m_run) begin
            m_run = 1; m_pc = RESET_PC;
        end else if (flush) begin
            m_pc = new_pc; m_idpc = 0; m_inst = 0; m_vld = 0;
        end else if (!stall) begin
            m_idpc = m_pc; m_inst = rom[a[9:2]]; m_vld = 1; m_cnt = m_cnt + 1;
            m_pc = branch_flag_i ? branch_target_addr_i : m_pc + 4;
        end
        @(posedge clk); #1;
    endtask

    task automatic ctl(input logic f, input logic s, input logic b,
                       input logic [31:0] npc, input logic [31:0] tgt);
        flush = f; stall = s; branch_flag_i = b; new_pc = npc; branch_target_addr_i = tgt;
    endtask

    task automatic apply_reset();
        ctl(0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act_vec() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", act_vec(),
                     {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
        end
        rst = 1'b0;
    endtask

    task automatic test_start();
        logic [31:0] exp_inst [3];
        exp_inst = '{32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 256; i++) rom[i] = i + 1;
        apply_reset();
        checks++;
        if (rom_ce_o !== 1'b0) begin
            failures++; $display("FAIL start_ce_idle got=%b want=0", rom_ce_o);
        end
        tick();
        checks++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL start_first_fetch ce=%b addr=%h vld=%b want ce=1 addr=0 vld=0",
                     rom_ce_o, rom_addr_o, id_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (id_inst_o !== exp_inst[i] || id_pc_o !== 32'(i * 4) || id_valid_o !== 1'b1
                || rom_addr_o !== 32'(i * 4 + 4)) begin
                failures++;
                $display("FAIL start_seq%0d inst=%h pc=%h vld=%b addr=%h want inst=%h pc=%h vld=1 addr=%h",
                         i, id_inst_o, id_pc_o, id_valid_o, rom_addr_o, exp_inst[i], i * 4, i * 4 + 4);
            end
        end
    endtask

    task automatic test_stall();
        tick();                       // now fetching 0x10
        ctl(0, 1, 1, 0, 32'h300);     // branch must be ignored while stalled
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rom_addr_o !== 32'h10 || id_pc_o !== 32'h0C || id_inst_o !== 32'd4
                || fetch_cnt_o !== 32'd4 || id_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d addr=%h pc=%h inst=%h cnt=%0d want addr=10 pc=0c inst=4 cnt=4",
                         i, rom_addr_o, id_pc_o, id_inst_o, fetch_cnt_o);
            end
        end
        ctl(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (id_pc_o !== 32'h10 || id_inst_o !== 32'd5 || fetch_cnt_o !== 32'd5 || rom_addr_o !== 32'h14) begin
            failures++;
            $display("FAIL stall_release pc=%h inst=%h cnt=%0d addr=%h want pc=10 inst=5 cnt=5 addr=14",
                     id_pc_o, id_inst_o, fetch_cnt_o, rom_addr_o);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        repeat (4) tick();            // fetching 0x0C
        ctl(0, 0, 1, 0, 32'h40);
        tick();
        checks++;
        if (id_pc_o !== 32'h0C || id_valid_o !== 1'b1 || id_inst_o !== 32'd4 || rom_addr_o !== 32'h40) begin
            failures++;
            $display("FAIL branch_delay_slot pc=%h vld=%b inst=%h addr=%h want pc=0c vld=1 inst=4 addr=40",
                     id_pc_o, id_valid_o, id_inst_o, rom_addr_o);
        end
        ctl(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (id_pc_o !== 32'h40 || id_inst_o !== 32'h11) begin
            failures++; $display("FAIL branch_target pc=%h inst=%h want pc=40 inst=11", id_pc_o, id_inst_o);
        end
        tick();
        checks++;
        if (id_pc_o !== 32'h44 || id_inst_o !== 32'h12) begin
            failures++; $display("FAIL branch_next pc=%h inst=%h want pc=44 inst=12", id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_priority();
        logic [31:0] cnt0;
        cnt0 = fetch_cnt_o;
        ctl(1, 1, 1, 32'h80, 32'h200);
        tick();
        checks++;
        if (rom_addr_o !== 32'h80 || id_inst_o !== 32'h0 || id_valid_o !== 1'b0
            || id_pc_o !== 32'h0 || fetch_cnt_o !== cnt0) begin
            failures++;
            $display("FAIL priority_flush addr=%h inst=%h vld=%b pc=%h cnt=%0d want addr=80 inst=0 vld=0 pc=0 cnt=%0d",
                     rom_addr_o, id_inst_o, id_valid_o, id_pc_o, fetch_cnt_o, cnt0);
        end
        ctl(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (id_pc_o !== 32'h80 || id_valid_o !== 1'b1 || id_inst_o !== 32'h21) begin
            failures++;
            $display("FAIL priority_after pc=%h vld=%b inst=%h want pc=80 vld=1 inst=21",
                     id_pc_o, id_valid_o, id_inst_o);
        end
    endtask

    task automatic test_wrap();
        ctl(1, 0, 0, 32'hFFFF_FFFE, 0);
        tick();
        checks++;
        if (rom_addr_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_align addr=%h want fffffffc", rom_addr_o);
        end
        ctl(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (rom_addr_o !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_zero addr=%h want 00000000", rom_addr_o);
        end
    endtask

    task automatic test_idle_ignore();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        ctl(1, 1, 1, 32'h500, 32'h600);
        tick();
        checks++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== RESET_PC || id_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore ce=%b addr=%h vld=%b want ce=1 addr=%h vld=0",
                     rom_ce_o, rom_addr_o, id_valid_o, RESET_PC);
        end
        ctl(0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        ctl(1, 1, 0, 32'h90, 0);      // mid-flush and stall
        #3 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++; $display("FAIL async_reset got=%h want=%h", act_vec(), exp_vec());
        end
        @(posedge clk); #1;
        ctl(0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        checks++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== RESET_PC || fetch_cnt_o !== 32'h0) begin
            failures++;
            $display("FAIL async_restart ce=%b addr=%h cnt=%0d want ce=1 addr=%h cnt=0",
                     rom_ce_o, rom_addr_o, fetch_cnt_o, RESET_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) apply_reset();
            ctl($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom, $urandom);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
        end
        ctl(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_start();
        test_stall();
        test_branch();
        test_priority();
        test_wrap();
        test_idle_ignore();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 stall  input  1  hold request from pipeline control; 1 = freeze PC and IF/ID outputs.
REQ-005 flush  input  1  pipeline flush; 1 = redirect to new_pc and kill the IF/ID slot.
REQ-006 new_pc  input  32  flush redirect address.
REQ-007 branch_flag_i  input  1  taken branch/jump resolved in ID.
REQ-008 branch_target_addr_i  input  32  branch/jump target.
REQ-009 rom_ce_o  output  1  instruction memory chip enable (`ChipEnable/`ChipDisable).
REQ-010 rom_addr_o  output  32  byte fetch address to instruction memory.
REQ-011 rom_inst_i  input  32  instruction word from memory; combinational, valid in the same cycle as rom_addr_o.
REQ-012 id_pc_o  output  32  PC of the instruction presented to ID.
REQ-013 id_inst_o  output  32  instruction presented to ID; `ZeroWord (nop) when not valid.
REQ-014 id_valid_o  output  1  id_inst_o is a real fetched instruction.
REQ-015 fetch_cnt_o  output  32  count of instructions handed to ID.

Function
REQ-016 States: IDLE (rom_ce_o = `ChipDisable) and RUN (rom_ce_o = `ChipEnable); the block enters IDLE on reset and moves to RUN on the first clock edge after rst deasserts.
REQ-017 In IDLE, pc = RESET_PC and id_valid_o = 0.
REQ-018 In RUN, rom_addr_o = {pc[31:2], 2'b00}; the low two bits are never driven nonzero.
REQ-019 Each RUN edge applies the first matching case in this priority order: flush > stall > branch > sequential.
REQ-020 flush: pc <= new_pc; id_inst_o <= `ZeroWord; id_valid_o <= 0; id_pc_o <= 0; fetch_cnt_o holds.
REQ-021 stall (no flush): pc, id_pc_o, id_inst_o, id_valid_o and fetch_cnt_o all hold; branch_flag_i is ignored, because ID re-presents the branch after the stall.
REQ-022 branch (no flush/stall): pc <= branch_target_addr_i.
REQ-023 branch: the word fetched in that cycle (delay slot) still passes to ID with id_valid_o = 1.
REQ-024 sequential: pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-025 In both the branch and sequential cases: id_pc_o <= pc, id_inst_o <= rom_inst_i, id_valid_o <= 1, fetch_cnt_o <= fetch_cnt_o + 1 (wraps modulo 2^32).
REQ-026 Fetch-to-ID latency is exactly one clock: the word at address A appears on id_inst_o the edge after rom_addr_o = A with no stall.
REQ-027 The first RUN cycle fetches RESET_PC; the first id_valid_o = 1 appears one edge later.
REQ-028 In IDLE, flush, stall and branch are ignored.

Reset
REQ-029 While rst = 1, regardless of clock, outputs take these values: state = IDLE, pc = RESET_PC, rom_ce_o = `ChipDisable, rom_addr_o = 0, id_pc_o = 0, id_inst_o = `ZeroWord, id_valid_o = 0, fetch_cnt_o = 0.
REQ-030 Reset asserted mid-operation (including during stall or flush) discards all in-flight state immediately.
REQ-031 After reset, restart follows REQ-016 and REQ-027.

Structure
REQ-032 Bus widths and constants come from the shared defines include, never local literals: `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable, `RstEnable.
REQ-033 A new `FetchIdle/`FetchRun state encoding is added to that shared defines include.
REQ-034 One sub-module, pc_reg (PC register with next-PC mux, ce generation and the IDLE/RUN state), is instantiated inside inst_fetch.
REQ-035 The IF/ID register and fetch counter live in inst_fetch itself.

Verification
REQ-036 Reset/start: RESET_PC = 0, ROM word[i] = i+1; release rst -> ce 0 for one cycle, then addr 0,4,8; id_inst_o = 1,2,3 on successive edges with id_pc_o = 0,4,8.
REQ-037 Stall: assert stall for 3 cycles at addr 0x10 -> addr stays 0x10, id outputs frozen, fetch_cnt_o unchanged; on release, next id_pc_o = 0x10.
REQ-038 Branch with delay slot: branch_flag_i = 1, target 0x40 while fetching 0x0C -> id_pc_o = 0x0C valid, then 0x40, 0x44.
REQ-039 Priority: flush = 1 (new_pc 0x80) together with stall = 1 and branch_flag_i = 1 -> next addr 0x80; id_inst_o = 0, id_valid_o = 0; following id_pc_o = 0x80.
REQ-040 Wrap and alignment: flush to new_pc 0xFFFF_FFFE -> rom_addr_o = 0xFFFF_FFFC, then 0x0000_0000.
REQ-041 Async reset: assert rst between clock edges mid-stream -> all outputs at REQ-029 values before the next edge.
